// File: rtl/pueo_trig_pkg.sv
// Shared types and constants for the PUEO trigger arbiter.
package pueo_trig_pkg;

    localparam int unsigned TRIG_ADDR_W = 12;
    localparam int unsigned META_W      = 8;
    localparam int unsigned SRCID_W     = 2;
    localparam int unsigned SEQ_W       = 5;
    localparam int unsigned HOLDOFF_W   = 16;
    localparam int unsigned DROP_W      = 16;
    localparam int unsigned PHASE_W     = 3;
    localparam int unsigned STAT_W      = 16;

    localparam logic [SRCID_W-1:0] SRC_SOFT = 2'd0;
    localparam logic [SRCID_W-1:0] SRC_PPS  = 2'd1;
    localparam logic [SRCID_W-1:0] SRC_EXT  = 2'd2;
    localparam logic [SRCID_W-1:0] SRC_RF   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } arb_state_t;

    // Metadata word: marker bit, source id, sequence count.
    typedef struct packed {
        logic               mark;
        logic [SRCID_W-1:0] src;
        logic [SEQ_W-1:0]   seq;
    } trig_meta_t;

    localparam trig_meta_t META_RESET = '{mark: 1'b1, src: '0, seq: '0};

endpackage

// File: rtl/pueo_trig_arbiter_if.sv
// Trigger-source / TURF-side signal bundle for pueo_trig_arbiter.
// grant_count_o exists only when PUEO_TRIG_ARB_STATS_EN is defined.
interface pueo_trig_arbiter_if #(
    parameter int unsigned NSRC = 4
);
    import pueo_trig_pkg::*;

    logic                          sysclk_phase_i;
    logic                          running_i;
    logic [NSRC-1:0]               src_req_i;
    logic [NSRC*TRIG_ADDR_W-1:0]   src_addr_i;
    logic [NSRC-1:0]               src_mask_i;
    logic [HOLDOFF_W-1:0]          holdoff_i;
    logic [TRIG_ADDR_W-1:0]        turf_trig_o;
    logic [META_W-1:0]             turf_metadata_o;
    logic                          turf_valid_o;
    logic [DROP_W-1:0]             dropped_o;
    logic                          busy_o;
`ifdef PUEO_TRIG_ARB_STATS_EN
    logic [NSRC*STAT_W-1:0]        grant_count_o;
`endif

    modport master (
        output sysclk_phase_i, running_i, src_req_i, src_addr_i, src_mask_i, holdoff_i,
        input  turf_trig_o, turf_metadata_o, turf_valid_o, dropped_o, busy_o
`ifdef PUEO_TRIG_ARB_STATS_EN
        , input grant_count_o
`endif
    );

    modport slave (
        input  sysclk_phase_i, running_i, src_req_i, src_addr_i, src_mask_i, holdoff_i,
        output turf_trig_o, turf_metadata_o, turf_valid_o, dropped_o, busy_o
`ifdef PUEO_TRIG_ARB_STATS_EN
        , output grant_count_o
`endif
    );

endinterface

// File: rtl/pueo_rr_arb.sv
// Combinational round-robin pick: first pending index at or after ptr, wrapping.
module pueo_rr_arb
    import pueo_trig_pkg::*;
#(
    parameter int unsigned NSRC = 4
) (
    input  logic [NSRC-1:0]    pending,
    input  logic [SRCID_W-1:0] ptr,
    output logic [SRCID_W-1:0] grant_c,
    output logic               any_c
);

    always_comb begin
        int unsigned j;
        logic [SRCID_W-1:0] idx;
        grant_c = '0;
        any_c   = 1'b0;
        j       = 0;
        idx     = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            j = 32'(ptr) + i;
            if (j >= NSRC) j = j - NSRC;
            idx = SRCID_W'(j);
            if (!any_c && pending[idx]) begin
                any_c   = 1'b1;
                grant_c = idx;
            end
        end
    end

endmodule

// File: rtl/pueo_trig_arbiter.sv
// Merges per-source trigger requests into the frame-aligned TURF trigger stream.
// Optional per-source grant counters: define PUEO_TRIG_ARB_STATS_EN.
module pueo_trig_arbiter
    import pueo_trig_pkg::*;
#(
    parameter int unsigned NSRC         = 4,
    parameter int unsigned PHASE_OFFSET = 2,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic               sysclk_i,
    input  logic               sysclk_rstn_i,
    pueo_trig_arbiter_if.slave bus
);

    localparam int unsigned VCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [PHASE_W-1:0]                  phase_cnt;
    logic [NSRC-1:0]                     pending, accept_c, drop_c, pend_next_c;
    logic [NSRC-1:0][TRIG_ADDR_W-1:0]    addr;
    logic [SRCID_W-1:0]                  ptr, grant_idx_c;
    logic                                any_c, capture_c, grant_c;
    arb_state_t                          state;
    logic [HOLDOFF_W-1:0]                hold_cnt, hold_dec_c;
    logic [VCNT_W-1:0]                   valid_cnt;
    logic [SEQ_W-1:0]                    seq;
    logic [TRIG_ADDR_W-1:0]              trig;
    trig_meta_t                          meta;
    logic                                valid, busy;
    logic [DROP_W-1:0]                   dropped, drop_next_c;
    logic [DROP_W:0]                     drop_sum_c;

    pueo_rr_arb #(.NSRC(NSRC)) u_rr_arb (
        .pending (pending),
        .ptr     (ptr),
        .grant_c (grant_idx_c),
        .any_c   (any_c)
    );

    assign capture_c  = (phase_cnt == PHASE_W'(PHASE_OFFSET));
    assign grant_c    = (state == ST_IDLE) && capture_c && any_c && bus.running_i;
    assign hold_dec_c = (hold_cnt == '0) ? '0 : hold_cnt - HOLDOFF_W'(1);

    // Request acceptance; drop decisions use the pre-edge busy/pending view.
    always_comb begin
        int unsigned ndrop;
        accept_c = '0;
        drop_c   = '0;
        ndrop    = 0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (bus.src_req_i[s] && !bus.src_mask_i[s] && bus.running_i) begin
                if (busy || pending[s]) begin
                    drop_c[s] = 1'b1;
                    ndrop     = ndrop + 1;
                end else begin
                    accept_c[s] = 1'b1;
                end
            end
        end
        drop_sum_c  = {1'b0, dropped} + (DROP_W+1)'(ndrop);
        drop_next_c = drop_sum_c[DROP_W] ? '1 : drop_sum_c[DROP_W-1:0];
        pend_next_c = pending | accept_c;
        if (grant_c) pend_next_c[grant_idx_c] = 1'b0;
        if (!bus.running_i) pend_next_c = '0;
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            phase_cnt <= '0;
            pending   <= '0;
            addr      <= '0;
            dropped   <= '0;
        end else begin
            phase_cnt <= bus.sysclk_phase_i ? '0 : phase_cnt + PHASE_W'(1);
            pending   <= pend_next_c;
            dropped   <= drop_next_c;
            for (int unsigned s = 0; s < NSRC; s++) begin
                if (accept_c[s]) addr[s] <= bus.src_addr_i[s*TRIG_ADDR_W +: TRIG_ADDR_W];
            end
        end
    end

    // Arbiter FSM; the holdoff counter runs from the grant edge through ISSUE and HOLDOFF.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            valid_cnt <= '0;
            seq       <= '0;
            trig      <= '0;
            meta      <= META_RESET;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        trig      <= addr[grant_idx_c];
                        meta      <= '{mark: 1'b1, src: grant_idx_c, seq: seq};
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        ptr       <= (grant_idx_c == SRCID_W'(NSRC-1)) ? '0
                                                                        : grant_idx_c + SRCID_W'(1);
                        hold_cnt  <= bus.holdoff_i;
                        valid_cnt <= VCNT_W'(HOLD_CYCLES-1);
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    hold_cnt <= hold_dec_c;
                    if (valid_cnt == '0) begin
                        valid <= 1'b0;
                        seq   <= seq + SEQ_W'(1);
                        if (hold_dec_c != '0) begin
                            state <= ST_HOLDOFF;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        valid_cnt <= valid_cnt - VCNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    hold_cnt <= hold_dec_c;
                    if (hold_cnt <= HOLDOFF_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PUEO_TRIG_ARB_STATS_EN
    logic [NSRC-1:0][STAT_W-1:0] grant_cnt;

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            grant_cnt <= '0;
        end else if (grant_c && (grant_cnt[grant_idx_c] != '1)) begin
            grant_cnt[grant_idx_c] <= grant_cnt[grant_idx_c] + STAT_W'(1);
        end
    end

    assign bus.grant_count_o = grant_cnt;
`endif

    assign bus.turf_trig_o     = trig;
    assign bus.turf_metadata_o = meta;
    assign bus.turf_valid_o    = valid;
    assign bus.dropped_o       = dropped;
    assign bus.busy_o          = busy;

endmodule

// File: doc/pueo_trig_arbiter.md
Name: pueo_trig_arbiter

Overview:
- Merges up to NSRC trigger requesters (soft, PPS, external, RF) into the single TURF trigger slot stream.
- Latches one address per requester and arbitrates round-robin among pending requesters.
- Enforces a global holdoff after every issued trigger.
- Emits address, metadata and valid aligned to the 8-clock sysclk_phase_i frame.
- Sits between the trigger sources and the TURF trigger output, in the sysclk domain.

Parameters:
- NSRC, 4, number of requesters (2..4; source id is 2 bits).
- PHASE_OFFSET, 2, clocks after the sysclk_phase_i pulse at which the capture/grant edge occurs (1..3).
- HOLD_CYCLES, 4, clocks that turf_valid_o stays high per trigger.

Ports:
- sysclk_i  in  1  system clock; sole clock.
- sysclk_rstn_i  in  1  reset; asynchronous assert, active-low.
- sysclk_phase_i  in  1  one-clock pulse every 8 clocks marking the frame start.
- running_i  in  1  triggers accepted only when high.
- src_req_i  in  NSRC  per-source one-clock request pulse.
- src_addr_i  in  NSRC*12  per-source address, sampled with its request.
- src_mask_i  in  NSRC  1 = source masked; its requests are ignored.
- holdoff_i  in  16  holdoff length in sysclk cycles; 0 = none.
- turf_trig_o  out  12  issued address.
- turf_metadata_o  out  8  bit 7 = 1; [6:5] = source id; [4:0] = sequence count.
- turf_valid_o  out  1  trigger valid.
- dropped_o  out  16  saturating count of dropped requests.
- busy_o  out  1  high in ISSUE or HOLDOFF.

Behaviour:
- Reset: all outputs 0 except turf_metadata_o = 8'h80. Pending flags cleared, round-robin pointer = 0, state IDLE, holdoff counter 0.
- Frame:
  - 3-bit phase counter is forced to 0 on sysclk_phase_i and otherwise increments, wrapping 7 to 0.
  - Capture edge = the clock at which the counter == PHASE_OFFSET.
  - A missing phase pulse lets the counter free-run.
- Acceptance, per source s, in the clock src_req_i[s]=1:
  - Masked, or running_i=0: ignored, not counted.
  - State HOLDOFF or ISSUE (busy_o=1): dropped, dropped_o += 1.
  - pending[s] already set: dropped, counted; the stored address is kept.
  - Otherwise: pending[s] <= 1, addr[s] <= src_addr_i[s].
  - Simultaneous requests from several sources are each accepted independently.
  - dropped_o saturates at 16'hFFFF.
- State machine IDLE / ISSUE / HOLDOFF:
  - IDLE:
    - On the capture edge with any pending and running_i=1, grant the first pending source at or after the pointer (ascending index, wrapping).
    - Register turf_trig_o = addr[g] and metadata {1, g, seq}.
    - Assert turf_valid_o starting the next clock.
    - Clear pending[g]; pointer <= g+1 mod NSRC; load the holdoff counter with holdoff_i; go to ISSUE.
    - A request arriving on the capture edge itself is not eligible until the next frame.
  - ISSUE:
    - turf_valid_o high for exactly HOLD_CYCLES clocks; address and metadata stable throughout.
    - On the last valid clock, seq <= seq+1 (5-bit wrap 31 to 0).
    - Then go to HOLDOFF if the counter is still nonzero, else IDLE.
  - HOLDOFF: the counter decrements each clock (it also decrements during ISSUE); go to IDLE when it reaches 0.
- Holdoff is measured from the grant edge. A holdoff_i shorter than HOLD_CYCLES therefore has no extra effect.
- running_i falling:
  - Pending flags clear the next clock.
  - An in-progress ISSUE completes normally.
- Other sources stay pending across the ISSUE/HOLDOFF of another source and compete at the next eligible capture edge.
- Reset mid-ISSUE: valid drops immediately (asynchronous) and the sequence count returns to 0.

Optional Feature:
- Macro PUEO_TRIG_ARB_STATS_EN.
- Defined: adds output grant_count_o (NSRC*16), one saturating grant counter per source, incremented at grant, cleared by reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package pueo_trig_pkg holds:
  - the arbiter state enum;
  - TRIG_ADDR_W=12, META_W=8, SRCID_W=2;
  - source id constants SRC_SOFT=0, SRC_PPS=1, SRC_EXT=2, SRC_RF=3.
- One sub-module, pueo_rr_arb: combinational round-robin pick of pending/pointer, returning a grant index and an any flag.

Test Plan:
- Source 0 requests addr 12'h123 at phase+5, holdoff_i=0 → valid for clocks 3..6 of the next frame (PHASE_OFFSET=2); turf_trig_o=123; metadata 8'h80; next trigger has metadata 8'h81.
- Sources 1 and 2 request in the same clock, holdoff_i=0 → source 1 issued in frame N, source 2 in frame N+1; metadata source id fields 1 then 2.
- holdoff_i=20, source 0 triggers, source 3 requests 10 clocks after the grant → dropped_o=1, nothing issued; a request at 25 clocks is issued.
- Source 2 requests twice before its grant → one trigger with the first address; dropped_o=1.
- src_mask_i[1]=1 or running_i=0 with requests → no valid; dropped_o unchanged.
- 33 consecutive triggers → sequence field wraps 31 to 0; assert sysclk_rstn_i low during ISSUE → valid=0 immediately and metadata=8'h80.
